// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
//   Receive-side result bus of the UART receiver, as seen by the downstream
//   consumer (FIFO / interface logic).
//
//   o_data      : last received byte, held until the next completed frame
//   o_rx_done   : one-clk strobe, high in the cycle o_data/o_frame_err update
//   o_frame_err : stop bit was sampled low on the last completed frame
//
//   modport master : the receiver, drives the bus
//   modport slave  : the consumer, observes the bus
// ----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;

    modport master (
        output o_data,
        output o_rx_done,
        output o_frame_err
    );

    modport slave (
        input o_data,
        input o_rx_done,
        input o_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   8N1-style UART receiver driven by an external oversampling tick.
//   The serial line is double-flopped into the clk domain, a start edge is
//   qualified at mid-bit, then every data bit and the stop bit is sampled one
//   bit period (OVERSAMPLING ticks) after the previous sample, i.e. mid-bit.
//   Data arrives LSB first.
//
//   Parameters:
//     NB_DATA      : data bits per frame
//     SB_TICK      : ticks spent in the stop bit (16 = 1 stop, 32 = 2 stop)
//     OVERSAMPLING : ticks per bit period, must match the tick generator
//
//   Ports:
//     clk     : system clock
//     i_rst   : asynchronous, active-high reset
//     i_tick  : oversampling tick, one clk wide
//     i_rx    : serial line, idle high, asynchronous to clk
//     rx_bus  : result bus (o_data, o_rx_done, o_frame_err), master side
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int NB_DATA      = 8,
    parameter int SB_TICK      = 16,
    parameter int OVERSAMPLING = 16
) (
    input  logic      clk,
    input  logic      i_rst,
    input  logic      i_tick,
    input  logic      i_rx,
    uart_rx_if.master rx_bus
);

    // tick_cnt must reach both the last tick of a data bit and of the stop bit
    localparam int TICK_MAX = (SB_TICK > OVERSAMPLING) ? SB_TICK : OVERSAMPLING;
    localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int BW       = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [TW-1:0] START_MID = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLING - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e             state_q,     state_d;
    logic [TW-1:0]      tick_cnt_q,  tick_cnt_d;
    logic [BW-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [NB_DATA-1:0] shift_q,     shift_d;
    logic [NB_DATA-1:0] data_q,      data_d;
    logic               rx_done_q,   rx_done_d;
    logic               frame_err_q, frame_err_d;
    logic [1:0]         sync_q,      sync_d;
    logic               rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level so a reset
    // never looks like a start edge.
    assign sync_d = {sync_q[0], i_rx};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        frame_err_d = frame_err_q;
        rx_done_d   = 1'b0;

        unique case (state_q)
            // The start-edge check runs every clk, not only on ticks, so
            // back-to-back frames are picked up one clk after STOP completes.
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end

            // Wait half a bit and re-check the line: a short low pulse is
            // treated as noise and dropped without touching the outputs.
            START: begin
                if (i_tick) begin
                    if (tick_cnt_q == START_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end

            // Shift right so the first (LSB) bit ends up in bit 0.
            DATA: begin
                if (i_tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[NB_DATA-1:1]};
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end

            // A low stop bit still delivers the byte; only the error flag
            // tells the consumer the frame was bad.
            STOP: begin
                if (i_tick) begin
                    if (tick_cnt_q == STOP_LAST) begin
                        tick_cnt_d  = '0;
                        data_d      = shift_q;
                        frame_err_d = ~rx_s;
                        rx_done_d   = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            sync_q      <= 2'b11;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            sync_q      <= sync_d;
        end
    end

    assign rx_bus.o_data      = data_q;
    assign rx_bus.o_rx_done   = rx_done_q;
    assign rx_bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//   Drives serial frames into uart_rx on a tick grid and compares every
//   o_rx_done event against a frame-level reference model: a frame is the
//   list of line levels seen at each bit centre, the byte is bits 1..8 LSB
//   first and the frame error is the inverse of the stop-bit level.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int NB_DATA      = 8;
    localparam int SB_TICK      = 16;
    localparam int OVERSAMPLING = 16;

    typedef struct {
        logic [NB_DATA-1:0] data;
        logic               ferr;
        longint             cyc;
    } rec_t;

    logic clk    = 1'b0;
    logic i_rst  = 1'b1;
    logic i_tick = 1'b0;
    logic i_rx   = 1'b1;

    uart_rx_if #(.NB_DATA(NB_DATA)) rx_bus ();

    uart_rx #(
        .NB_DATA      (NB_DATA),
        .SB_TICK      (SB_TICK),
        .OVERSAMPLING (OVERSAMPLING)
    ) dut (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_tick (i_tick),
        .i_rx   (i_rx),
        .rx_bus (rx_bus)
    );

    always #5 clk = ~clk;

    // Tick generator: one clk-wide pulse every tick_div clks while enabled.
    int     tick_div = 163;
    bit     tick_en  = 1'b0;
    int     tick_ctr = 0;
    longint cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!tick_en) begin
            i_tick   = 1'b0;
            tick_ctr = 0;
        end else if (tick_ctr >= tick_div - 1) begin
            i_tick   = 1'b1;
            tick_ctr = 0;
        end else begin
            i_tick   = 1'b0;
            tick_ctr = tick_ctr + 1;
        end
    end

    // Event recorder: logs every done pulse and counts protocol violations
    // (double-wide pulses, outputs moving without a pulse).
    rec_t               got_q[$];
    int                 dbl_cnt       = 0;
    int                 chg_cnt       = 0;
    logic               mon_prev_done = 1'b0;
    logic [NB_DATA-1:0] mon_prev_data = '0;
    logic               mon_prev_ferr = 1'b0;
    rec_t               mon_rec;

    always @(negedge clk) begin
        if (!i_rst) begin
            if (rx_bus.o_rx_done === 1'b1) begin
                mon_rec.data = rx_bus.o_data;
                mon_rec.ferr = rx_bus.o_frame_err;
                mon_rec.cyc  = cyc;
                got_q.push_back(mon_rec);
                if (mon_prev_done) dbl_cnt = dbl_cnt + 1;
            end else if (rx_bus.o_data !== mon_prev_data ||
                         rx_bus.o_frame_err !== mon_prev_ferr) begin
                chg_cnt = chg_cnt + 1;
            end
            mon_prev_done = rx_bus.o_rx_done;
        end else begin
            mon_prev_done = 1'b0;
        end
        mon_prev_data = rx_bus.o_data;
        mon_prev_ferr = rx_bus.o_frame_err;
    end

    // Scoreboard state (owned by the stimulus process).
    rec_t               exp_q[$];
    int                 rd_idx    = 0;
    int                 n_checks  = 0;
    int                 n_fail    = 0;
    logic [NB_DATA-1:0] last_data = '0;
    logic               last_ferr = 1'b0;
    bit                 tick_lost = 1'b0;

    // Reference model: decode a frame from its bit-centre line levels.
    function automatic rec_t model_frame(input logic line [0:NB_DATA+1]);
        rec_t r;
        for (int i = 0; i < NB_DATA; i++) r.data[i] = line[i+1];
        r.ferr = !line[NB_DATA+1];
        r.cyc  = 0;
        return r;
    endfunction

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            if (tick_lost) break;
            @(posedge clk);
            while (i_tick !== 1'b1 && guard < 2000) begin
                @(posedge clk);
                guard++;
            end
            if (guard >= 2000) begin
                tick_lost = 1'b1;
                n_checks++;
                n_fail++;
                $display("[TB] FAIL tick_wait: no tick within %0d clks, need 1", guard);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int nt);
        i_rx = v;
        wait_ticks(nt);
    endtask

    // Sends one frame; a bad stop bit is held low for 12 ticks (covering the
    // sample point) and then released so the re-armed START rejects it.
    task automatic send_frame(input logic [NB_DATA-1:0] b, input bit stop_ok);
        logic line [0:NB_DATA+1];
        line[0] = 1'b0;
        for (int i = 0; i < NB_DATA; i++) line[i+1] = b[i];
        line[NB_DATA+1] = stop_ok;
        for (int i = 0; i <= NB_DATA; i++) drive_bit(line[i], OVERSAMPLING);
        if (stop_ok) begin
            drive_bit(1'b1, SB_TICK);
        end else begin
            drive_bit(1'b0, 12);
            drive_bit(1'b1, SB_TICK - 12);
        end
        exp_q.push_back(model_frame(line));
    endtask

    task automatic test_reset();
        rec_t e;
        i_rst    = 1'b1;
        i_rx     = 1'b1;
        tick_div = 163;
        tick_en  = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_bus.o_data !== 8'h00) begin
            n_fail++; $display("[TB] FAIL reset_data: got %h expected 00", rx_bus.o_data);
        end
        n_checks++;
        if (rx_bus.o_rx_done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", rx_bus.o_rx_done);
        end
        n_checks++;
        if (rx_bus.o_frame_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_ferr: got %b expected 0", rx_bus.o_frame_err);
        end
        i_rst = 1'b0;
        wait_ticks(4);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++; $display("[TB] FAIL reset_idle_pulses: got %0d expected 0", got_q.size());
        end
        e = '{data: '0, ferr: 1'b0, cyc: 0};
        last_data = e.data;
        last_ferr = e.ferr;
    endtask

    task automatic test_single();
        rec_t e, g;
        send_frame(8'h55, 1'b1);
        wait_ticks(20);
        n_checks++;
        if (got_q.size() != rd_idx + exp_q.size()) begin
            n_fail++; $display("[TB] FAIL single_count: got %0d expected %0d", got_q.size() - rd_idx, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            e = exp_q.pop_front(); g = got_q[rd_idx]; rd_idx++;
            n_checks++;
            if (g.data !== e.data) begin n_fail++; $display("[TB] FAIL single_data: got %h expected %h", g.data, e.data); end
            n_checks++;
            if (g.ferr !== e.ferr) begin n_fail++; $display("[TB] FAIL single_ferr: got %b expected %b", g.ferr, e.ferr); end
            last_data = e.data; last_ferr = e.ferr;
        end
        exp_q.delete(); rd_idx = got_q.size();
        n_checks++;
        if (rx_bus.o_data !== last_data) begin
            n_fail++; $display("[TB] FAIL single_hold: got %h expected %h", rx_bus.o_data, last_data);
        end
    endtask

    task automatic test_back_to_back();
        rec_t   e, g;
        longint gap;
        tick_div = 4;
        wait_ticks(20);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_ticks(20);
        n_checks++;
        if (got_q.size() != rd_idx + exp_q.size()) begin
            n_fail++; $display("[TB] FAIL b2b_count: got %0d expected %0d", got_q.size() - rd_idx, exp_q.size());
        end
        if (got_q.size() >= rd_idx + 2) begin
            gap = got_q[rd_idx+1].cyc - got_q[rd_idx].cyc;
            n_checks++;
            if (gap < 639 || gap > 641) begin
                n_fail++; $display("[TB] FAIL b2b_spacing: got %0d clks expected 640", gap);
            end
        end
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            e = exp_q.pop_front(); g = got_q[rd_idx]; rd_idx++;
            n_checks++;
            if (g.data !== e.data) begin n_fail++; $display("[TB] FAIL b2b_data: got %h expected %h", g.data, e.data); end
            n_checks++;
            if (g.ferr !== e.ferr) begin n_fail++; $display("[TB] FAIL b2b_ferr: got %b expected %b", g.ferr, e.ferr); end
            last_data = e.data; last_ferr = e.ferr;
        end
        exp_q.delete(); rd_idx = got_q.size();
    endtask

    task automatic test_glitch();
        rec_t e, g;
        i_rx = 1'b0;
        wait_ticks(4);
        i_rx = 1'b1;
        wait_ticks(30);
        n_checks++;
        if (got_q.size() != rd_idx) begin
            n_fail++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", got_q.size() - rd_idx);
        end
        n_checks++;
        if (rx_bus.o_data !== last_data) begin
            n_fail++; $display("[TB] FAIL glitch_data_hold: got %h expected %h", rx_bus.o_data, last_data);
        end
        rd_idx = got_q.size();
        send_frame(8'h81, 1'b1);
        wait_ticks(20);
        n_checks++;
        if (got_q.size() != rd_idx + exp_q.size()) begin
            n_fail++; $display("[TB] FAIL glitch_count: got %0d expected %0d", got_q.size() - rd_idx, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            e = exp_q.pop_front(); g = got_q[rd_idx]; rd_idx++;
            n_checks++;
            if (g.data !== e.data) begin n_fail++; $display("[TB] FAIL glitch_data: got %h expected %h", g.data, e.data); end
            n_checks++;
            if (g.ferr !== e.ferr) begin n_fail++; $display("[TB] FAIL glitch_ferr: got %b expected %b", g.ferr, e.ferr); end
            last_data = e.data; last_ferr = e.ferr;
        end
        exp_q.delete(); rd_idx = got_q.size();
    endtask

    task automatic test_frame_err();
        rec_t e, g;
        send_frame(8'hFF, 1'b0);
        send_frame(8'h12, 1'b1);
        wait_ticks(20);
        n_checks++;
        if (got_q.size() != rd_idx + exp_q.size()) begin
            n_fail++; $display("[TB] FAIL ferr_count: got %0d expected %0d", got_q.size() - rd_idx, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            e = exp_q.pop_front(); g = got_q[rd_idx]; rd_idx++;
            n_checks++;
            if (g.data !== e.data) begin n_fail++; $display("[TB] FAIL ferr_data: got %h expected %h", g.data, e.data); end
            n_checks++;
            if (g.ferr !== e.ferr) begin n_fail++; $display("[TB] FAIL ferr_flag: got %b expected %b", g.ferr, e.ferr); end
            last_data = e.data; last_ferr = e.ferr;
        end
        exp_q.delete(); rd_idx = got_q.size();
        n_checks++;
        if (rx_bus.o_frame_err !== last_ferr) begin
            n_fail++; $display("[TB] FAIL ferr_clear: got %b expected %b", rx_bus.o_frame_err, last_ferr);
        end
    endtask

    task automatic test_reset_mid();
        rec_t             e, g;
        logic [NB_DATA-1:0] b;
        b = 8'h3C;
        wait_ticks(5);
        drive_bit(1'b0, OVERSAMPLING);
        for (int i = 0; i < 3; i++) drive_bit(b[i], OVERSAMPLING);
        drive_bit(b[3], 6);
        i_rst = 1'b1;
        i_rx  = 1'b1;
        #1;
        n_checks++;
        if (rx_bus.o_data !== 8'h00) begin
            n_fail++; $display("[TB] FAIL midrst_data: got %h expected 00", rx_bus.o_data);
        end
        n_checks++;
        if (rx_bus.o_rx_done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midrst_done: got %b expected 0", rx_bus.o_rx_done);
        end
        last_data = '0;
        last_ferr = 1'b0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        wait_ticks(40);
        n_checks++;
        if (got_q.size() != rd_idx) begin
            n_fail++; $display("[TB] FAIL midrst_pulses: got %0d expected 0", got_q.size() - rd_idx);
        end
        rd_idx = got_q.size();
        send_frame(b, 1'b1);
        wait_ticks(20);
        n_checks++;
        if (got_q.size() != rd_idx + exp_q.size()) begin
            n_fail++; $display("[TB] FAIL midrst_count: got %0d expected %0d", got_q.size() - rd_idx, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            e = exp_q.pop_front(); g = got_q[rd_idx]; rd_idx++;
            n_checks++;
            if (g.data !== e.data) begin n_fail++; $display("[TB] FAIL midrst_rx_data: got %h expected %h", g.data, e.data); end
            n_checks++;
            if (g.ferr !== e.ferr) begin n_fail++; $display("[TB] FAIL midrst_rx_ferr: got %b expected %b", g.ferr, e.ferr); end
            last_data = e.data; last_ferr = e.ferr;
        end
        exp_q.delete(); rd_idx = got_q.size();
    endtask

    task automatic test_freeze();
        rec_t e, g;
        tick_en = 1'b0;
        @(negedge clk);
        i_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            i_rx = 1'($urandom);
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        i_rx = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_q.size() != rd_idx) begin
            n_fail++; $display("[TB] FAIL freeze_pulses: got %0d expected 0", got_q.size() - rd_idx);
        end
        rd_idx  = got_q.size();
        tick_en = 1'b1;
        wait_ticks(20);
        send_frame(8'hC5, 1'b1);
        wait_ticks(20);
        n_checks++;
        if (got_q.size() != rd_idx + exp_q.size()) begin
            n_fail++; $display("[TB] FAIL freeze_count: got %0d expected %0d", got_q.size() - rd_idx, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            e = exp_q.pop_front(); g = got_q[rd_idx]; rd_idx++;
            n_checks++;
            if (g.data !== e.data) begin n_fail++; $display("[TB] FAIL freeze_data: got %h expected %h", g.data, e.data); end
            n_checks++;
            if (g.ferr !== e.ferr) begin n_fail++; $display("[TB] FAIL freeze_ferr: got %b expected %b", g.ferr, e.ferr); end
            last_data = e.data; last_ferr = e.ferr;
        end
        exp_q.delete(); rd_idx = got_q.size();
    endtask

    task automatic test_random();
        rec_t e, g;
        int   gap;
        tick_div = $urandom_range(4, 8);
        wait_ticks(20);
        for (int f = 0; f < 8; f++) begin
            send_frame(8'($urandom), ($urandom_range(0, 3) != 0));
            gap = $urandom_range(0, 5);
            if (gap > 0) drive_bit(1'b1, gap);
        end
        wait_ticks(20);
        n_checks++;
        if (got_q.size() != rd_idx + exp_q.size()) begin
            n_fail++; $display("[TB] FAIL rand_count: got %0d expected %0d", got_q.size() - rd_idx, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            e = exp_q.pop_front(); g = got_q[rd_idx]; rd_idx++;
            n_checks++;
            if (g.data !== e.data) begin n_fail++; $display("[TB] FAIL rand_data: got %h expected %h", g.data, e.data); end
            n_checks++;
            if (g.ferr !== e.ferr) begin n_fail++; $display("[TB] FAIL rand_ferr: got %b expected %b", g.ferr, e.ferr); end
            last_data = e.data; last_ferr = e.ferr;
        end
        exp_q.delete(); rd_idx = got_q.size();
        n_checks++;
        if (dbl_cnt != 0) begin
            n_fail++; $display("[TB] FAIL done_width: got %0d double pulses expected 0", dbl_cnt);
        end
        n_checks++;
        if (chg_cnt != 0) begin
            n_fail++; $display("[TB] FAIL output_stability: got %0d unstrobed changes expected 0", chg_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_freeze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Directly downstream of the baud-rate tick generator.
- Consumes its 16x-oversampled tick to sample the serial line and deserialise 8N1 frames, LSB first.
- Delivers each received byte with a one-cycle done strobe and a frame-error flag to the RX-side consumer (FIFO/interface logic).

Parameters:
- NB_DATA, 8, number of data bits per frame.
- SB_TICK, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
- OVERSAMPLING, 16, ticks per bit period; must match the tick generator.

Ports:
- clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_tick  input  1  oversampling tick, one clk cycle wide, OVERSAMPLING per bit.
- i_rx  input  1  serial line, idle high, asynchronous to clk.
- o_data  output  NB_DATA  last received byte, held until next completed frame.
- o_rx_done  output  1  one-cycle pulse when o_data/o_frame_err are updated.
- o_frame_err  output  1  stop bit sampled low on last frame; held until next completed frame.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; tick_cnt=0; bit_cnt=0; shift register=0.
  - Both synchroniser flops=1.
  - o_data=0, o_rx_done=0, o_frame_err=0.
- Input synchroniser: i_rx passes two flops (rx_s) before use; 2-clk latency. All decisions below use rx_s.
- Tick gating: tick_cnt advances and samples are taken only in cycles with i_tick=1. With i_tick=0, state, counters and shift register hold. The IDLE falling-edge check is the only exception; it is evaluated every clk.
- Counter widths: tick_cnt wide enough for SB_TICK-1; bit_cnt wide enough for NB_DATA-1. Both reset to 0 on every state entry.
- FSM, states IDLE, START, DATA, STOP:
  - IDLE:
    - rx_s=0 -> START, tick_cnt=0.
  - START (finds mid-bit):
    - On tick with tick_cnt==OVERSAMPLING/2-1 (7): if rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0. Else false start/glitch -> IDLE, no outputs change.
    - Other ticks: tick_cnt+1.
  - DATA:
    - On tick with tick_cnt==OVERSAMPLING-1: shift rx_s into MSB of shift register (shift right, so first bit ends in LSB). tick_cnt=0.
    - If bit_cnt==NB_DATA-1 -> STOP, else bit_cnt+1.
    - Other ticks: tick_cnt+1.
  - STOP:
    - On tick with tick_cnt==SB_TICK-1: o_data<=shift register, o_frame_err<=~rx_s, o_rx_done<=1 for exactly one clk; -> IDLE.
    - Other ticks: tick_cnt+1.
- Sample point: every data/stop bit is sampled at 16 ticks after the previous mid-bit, i.e. mid-bit.
- Latency:
  - o_rx_done rises the clk after the tick that completes STOP (registered output).
  - STOP -> IDLE means a new start edge is accepted the following clk. Back-to-back frames are supported with no idle gap beyond the stop bit.
- Frame error: byte is still delivered (o_data updated, o_rx_done pulsed); only o_frame_err=1. Receiver does not wait for line high before re-arming; a line held low re-enters START immediately, and START then validates it.
- Reset mid-frame: immediate return to IDLE, outputs cleared, partial byte discarded. No o_rx_done pulse for the aborted frame.
- o_rx_done is never asserted two consecutive cycles; o_data and o_frame_err never change except in the cycle o_rx_done rises.

Test Plan:
- Drive i_tick every 163 clk (50 MHz/19200/16); send frame 0x55 with stop=1 -> single o_rx_done pulse, o_data=0x55, o_frame_err=0, FSM back in IDLE.
- Back-to-back frames 0xA3 then 0x0F, no idle gap -> two o_rx_done pulses ~160 ticks apart; o_data=0xA3 then 0x0F; o_frame_err=0 both times.
- Low glitch on i_rx lasting 4 ticks, then high -> START aborts at tick 7, no o_rx_done, o_data unchanged; next 0x81 frame received correctly.
- Frame 0xFF with stop bit driven 0 -> o_rx_done pulses, o_data=0xFF, o_frame_err=1. Following valid frame 0x12 -> o_frame_err returns to 0.
- Assert i_rst during DATA after 3 bits of 0x3C -> o_data=0, o_rx_done=0, state IDLE immediately. Full 0x3C frame after release -> o_data=0x3C.
- Hold i_tick=0 while i_rx falls and toggles -> FSM enters START but tick_cnt/bit_cnt frozen, no o_rx_done. Resume ticks with a clean frame 0xC5 -> o_data=0xC5.
